sync_fifo_reader: RTL

Read-side drain engine for the counted synchronous FIFO. It drives the FIFO's rd_en from empty and fifo_cnt, and absorbs the FIFO's 1-cycle registered read latency. It presents the words downstream as a valid/ready stream at full throughput, one word per clock. It sits between the FIFO's read port and any stream consumer, replacing ad-hoc rd_en stimulus.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_reader_if.sv | 31 +++
 rtl/sync_fifo_reader_skid_buf.sv | 74 +++++++
 rtl/sync_fifo_reader.sv | 114 +++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the counted synchronous FIFO and its read-side drain engine:
// default sizes, the fill-count width helper and the reader hold-off state type.
package sync_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DATA_DEPTH_DEF = 8;

  // Fill count must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } reader_state_t;

endpackage

// File: rtl/sync_fifo_reader_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream seen by
// sync_fifo_reader. master = the reader, slave = FIFO plus stream consumer.
interface sync_fifo_reader_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DATA_DEPTH = DATA_DEPTH_DEF
);

  localparam int CNT_W = cnt_w(DATA_DEPTH);

  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [15:0]           xfer_cnt;

  modport master (
    input  fifo_empty, fifo_cnt, fifo_data_out, m_ready,
    output fifo_rd_en, m_data, m_valid, xfer_cnt
  );

  modport slave (
    output fifo_empty, fifo_cnt, fifo_data_out, m_ready,
    input  fifo_rd_en, m_data, m_valid, xfer_cnt
  );

endinterface

// File: rtl/sync_fifo_reader_skid_buf.sv
// stream_skid_buf_2: two-entry in-order buffer (head/tail). Head is the entry
// presented downstream. The caller guarantees no push while full without a pop.
module stream_skid_buf_2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // Next buffer contents: a landing word always goes behind whatever survives the pop.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = push_data;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d = push_data;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            occ_d  = 2'd1;
          end
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  // Occupancy and head are cleared so the stream reads idle/zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
    end
  end

  // Tail only matters while occ is 2, so it carries no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign head_data = head_q;
  assign occ       = occ_q;

endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: drains a counted synchronous FIFO (1-cycle registered read)
// into a full-throughput valid/ready stream through a 2-entry skid buffer.
// Optional macro SYNC_FIFO_READER_THRESH_EN adds a flush port and an IDLE/DRAIN
// hold-off FSM that waits for RD_THRESH words (or a flush) before reading.
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DATA_DEPTH = DATA_DEPTH_DEF,
  parameter int RD_THRESH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SYNC_FIFO_READER_THRESH_EN
  input  logic                    flush,
`endif
  sync_fifo_reader_if.master      bus
);

  localparam int               CNT_W    = cnt_w(DATA_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(RD_THRESH);

  logic                  infl_q, infl_d;
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  m_valid;
  logic                  pop;
  logic [2:0]            committed;
  logic                  rd_room;
  logic                  rd_gate;
  logic                  rd_en;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & bus.m_ready;

  // Slots already spoken for after this cycle's pop; 3 bits so it never wraps.
  assign committed = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
  assign rd_room   = !bus.fifo_empty && (committed < 3'd2);
  assign rd_en     = rd_room && rd_gate;

`ifdef SYNC_FIFO_READER_THRESH_EN
  reader_state_t state_q, state_d;

  // Hold-off FSM: start once enough words are queued or on flush, stop when dry.
  always_comb begin
    state_d = state_q;
    rd_gate = 1'b0;
    case (state_q)
      IDLE: begin
        if ((bus.fifo_cnt >= THRESH_C) || (flush && !bus.fifo_empty)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_gate = 1'b1;
        if (bus.fifo_empty && !rd_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold-off state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  logic unused_cfg;

  assign rd_gate    = 1'b1;
  assign unused_cfg = ^{bus.fifo_cnt, THRESH_C};
`endif

  // Read in flight tracks the FIFO's registered read latency; beats counted on pop.
  always_comb begin
    infl_d     = rd_en;
    xfer_cnt_d = xfer_cnt_q + {15'd0, pop};
  end

  // Control state; reset discards any word still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q     <= 1'b0;
      xfer_cnt_q <= 16'd0;
    end else begin
      infl_q     <= infl_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  stream_skid_buf_2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data (bus.fifo_data_out),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = head_data;
  assign bus.m_valid    = m_valid;
  assign bus.xfer_cnt   = xfer_cnt_q;

endmodule
